// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: in-order allocate, out-of-order completion,
// in-order retirement of up to COMMIT_WIDTH entries per cycle, and branch flush.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   alloc_valid/ready          dispatch handshake; alloc_tag is the tail slot
//   alloc_pd_new/pd_old/has_rd/pc  per-entry payload captured on accept
//   wb_valid/wb_tag            NUM_WB completion ports (packed tags)
//   br_valid/br_tag            branch resolution, also marks the branch done
//   br_mispredict/br_target_pc flush everything younger than br_tag
//   retire_valid/has_rd/pd_old thermometer retire slots, pregs to free
//   head, count, full, empty   occupancy status
//   mispredict/_tag/_pc        one-cycle flush pulse with recovery info
module rob_multi #(
    parameter int DEPTH        = 16,
    parameter int COMMIT_WIDTH = 2,
    parameter int NUM_WB       = 3,
    parameter int PREG_W       = 7,
    parameter int TAG_W        = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_valid,
    input  logic [PREG_W-1:0]              alloc_pd_new,
    input  logic [PREG_W-1:0]              alloc_pd_old,
    input  logic                           alloc_has_rd,
    input  logic [31:0]                    alloc_pc,
    output logic                           alloc_ready,
    output logic [TAG_W-1:0]               alloc_tag,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]        wb_tag,
    input  logic                           br_valid,
    input  logic [TAG_W-1:0]               br_tag,
    input  logic                           br_mispredict,
    input  logic [31:0]                    br_target_pc,
    output logic [COMMIT_WIDTH-1:0]        retire_valid,
    output logic [COMMIT_WIDTH-1:0]        retire_has_rd,
    output logic [COMMIT_WIDTH*PREG_W-1:0] retire_pd_old,
    output logic [TAG_W-1:0]               head,
    output logic                           mispredict,
    output logic [TAG_W-1:0]               mispredict_tag,
    output logic [31:0]                    mispredict_pc,
    output logic [TAG_W:0]                 count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = TAG_W + 1;

    // Control state
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic              mispredict_q, mispredict_d;
    logic [TAG_W-1:0]  mis_tag_q, mis_tag_d;
    logic [31:0]       mis_pc_q, mis_pc_d;

    // Payload state, written only on allocation
    logic [DEPTH-1:0]  has_rd_q;
    logic [PREG_W-1:0] pd_new_q [DEPTH];
    logic [PREG_W-1:0] pd_old_q [DEPTH];
    logic [31:0]       pc_q     [DEPTH];

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic [PTR_W-1:0]  count_w;
    logic              full_w;
    logic              alloc_fire;
    logic              flush;
    logic [TAG_W-1:0]  br_age;
    logic [DEPTH-1:0]  young;
    logic [DEPTH-1:0]  wb_hit;
    logic [TAG_W-1:0]  ret_idx [COMMIT_WIDTH];
    logic [PTR_W-1:0]  n_ret;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign count_w  = tail_q - head_q;
    assign full_w   = (count_w == PTR_W'(DEPTH));

    assign alloc_ready = !full_w && !mispredict_q;
    assign alloc_tag   = tail_idx;
    assign head        = head_idx;
    assign count       = count_w;
    assign full        = full_w;
    assign empty       = (count_w == '0);

    assign mispredict     = mispredict_q;
    assign mispredict_tag = mis_tag_q;
    assign mispredict_pc  = mis_pc_q;

    // A mispredict on a slot that holds no live instruction is stale; ignore it.
    assign flush      = br_valid && br_mispredict && valid_q[br_tag];
    assign alloc_fire = alloc_valid && alloc_ready && !flush;

    // Age is the distance from head, so comparisons survive pointer wrap.
    assign br_age = br_tag - head_idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign young[i] = (TAG_W'(i) - head_idx) > br_age;
    end

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_ridx
        assign ret_idx[k] = head_idx + TAG_W'(k);
    end

    // Completion strobes, folded into one per-entry hit vector
    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                wb_hit[wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            end
        end
        if (br_valid) begin
            wb_hit[br_tag] = 1'b1;
        end
    end

    // Retire window: a chain that breaks at the first not-ready entry,
    // which makes retire_valid a thermometer code by construction.
    always_comb begin
        logic ok;
        ok            = 1'b1;
        n_ret         = '0;
        retire_valid  = '0;
        retire_has_rd = '0;
        retire_pd_old = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            ok = ok && valid_q[ret_idx[k]] && done_q[ret_idx[k]]
                 && (count_w > PTR_W'(k));
            retire_valid[k]  = ok;
            retire_has_rd[k] = ok && has_rd_q[ret_idx[k]];
            retire_pd_old[k*PREG_W +: PREG_W] = pd_old_q[ret_idx[k]];
            n_ret = n_ret + {{TAG_W{1'b0}}, ok};
        end
    end

    // Next-state for control
    always_comb begin
        logic [DEPTH-1:0] kill;
        kill    = {DEPTH{flush}} & young;
        valid_d = valid_q;
        done_d  = done_q | (wb_hit & valid_q & ~kill);

        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (retire_valid[k]) begin
                valid_d[ret_idx[k]] = 1'b0;
                done_d[ret_idx[k]]  = 1'b0;
            end
        end

        valid_d = valid_d & ~kill;
        done_d  = done_d & ~kill;

        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end

        head_d = head_q + n_ret;
        tail_d = tail_q + (alloc_fire ? PTR_W'(1) : PTR_W'(0));
        // Rebuilding tail from head keeps the wrap bit consistent.
        if (flush) begin
            tail_d = head_q + {1'b0, br_age} + PTR_W'(1);
        end

        mispredict_d = flush;
        mis_tag_d    = flush ? br_tag : mis_tag_q;
        mis_pc_d     = flush ? br_target_pc : mis_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            mispredict_q <= 1'b0;
            mis_tag_q    <= '0;
            mis_pc_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            mispredict_q <= mispredict_d;
            mis_tag_q    <= mis_tag_d;
            mis_pc_q     <= mis_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[tail_idx] <= alloc_has_rd;
            pd_new_q[tail_idx] <= alloc_pd_new;
            pd_old_q[tail_idx] <= alloc_pd_old;
            pc_q[tail_idx]     <= alloc_pc;
        end
    end

    // pd_new and pc are held for debug visibility; no output reads them.
    logic unused_payload;
    always_comb begin
        unused_payload = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_payload = unused_payload ^ (^{pd_new_q[i], pc_q[i]});
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi with a retire/mispredict scoreboard.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_rob_multi;

    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int NWB   = 3;
    localparam int PW    = 7;
    localparam int TW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alloc_valid;
    logic [PW-1:0]   alloc_pd_new;
    logic [PW-1:0]   alloc_pd_old;
    logic            alloc_has_rd;
    logic [31:0]     alloc_pc;
    logic            alloc_ready;
    logic [TW-1:0]   alloc_tag;
    logic [NWB-1:0]  wb_valid;
    logic [NWB*TW-1:0] wb_tag;
    logic            br_valid;
    logic [TW-1:0]   br_tag;
    logic            br_mispredict;
    logic [31:0]     br_target_pc;
    logic [CW-1:0]   retire_valid;
    logic [CW-1:0]   retire_has_rd;
    logic [CW*PW-1:0] retire_pd_old;
    logic [TW-1:0]   head;
    logic            mispredict;
    logic [TW-1:0]   mispredict_tag;
    logic [31:0]     mispredict_pc;
    logic [TW:0]     count;
    logic            full;
    logic            empty;

    rob_multi #(
        .DEPTH(DEPTH), .COMMIT_WIDTH(CW), .NUM_WB(NWB), .PREG_W(PW), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new),
        .alloc_pd_old(alloc_pd_old), .alloc_has_rd(alloc_has_rd),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .br_target_pc(br_target_pc),
        .retire_valid(retire_valid), .retire_has_rd(retire_has_rd),
        .retire_pd_old(retire_pd_old), .head(head),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .mispredict_pc(mispredict_pc),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_ret[$];
    logic [35:0] exp_mis[$];
    logic [7:0]  e_ret;
    logic [35:0] e_mis;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alloc_valid   = 1'b0;
        wb_valid      = '0;
        br_valid      = 1'b0;
        br_mispredict = 1'b0;
    endtask

    task automatic alloc(input logic [PW-1:0] pd, input logic hr);
        alloc_valid  = 1'b1;
        alloc_pd_old = pd;
        alloc_pd_new = pd + 7'd64;
        alloc_has_rd = hr;
        alloc_pc     = 32'h1000 + {25'd0, pd};
        step();
        alloc_valid  = 1'b0;
    endtask

    task automatic wb(input int p, input logic [TW-1:0] tag);
        wb_valid[p]        = 1'b1;
        wb_tag[p*TW +: TW] = tag;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    // Monitor: every presented retire slot / flush pulse consumes one expectation.
    always @(negedge clk) begin
        if (retire_valid != '0) begin
            chk("retire_thermo", retire_valid[1] & ~retire_valid[0], 0);
        end
        for (int k = 0; k < CW; k++) begin
            if (retire_valid[k]) begin
                if (exp_ret.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected: slot %0d pd_old %0d, expected none",
                             k, retire_pd_old[k*PW +: PW]);
                end else begin
                    e_ret = exp_ret.pop_front();
                    chk("retire_pd_old", retire_pd_old[k*PW +: PW], e_ret[6:0]);
                    chk("retire_has_rd", retire_has_rd[k], e_ret[7]);
                end
            end
        end
        if (mispredict) begin
            if (exp_mis.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mispredict_unexpected: tag %0d, expected none",
                         mispredict_tag);
            end else begin
                e_mis = exp_mis.pop_front();
                chk("mispredict_tag", mispredict_tag, e_mis[35:32]);
                chk("mispredict_pc", mispredict_pc, e_mis[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        alloc_pd_new = '0;
        alloc_pd_old = '0;
        alloc_has_rd = 1'b0;
        alloc_pc     = '0;
        wb_tag       = '0;
        br_tag       = '0;
        br_target_pc = '0;
        idle();
        step();
        step();
        reset = 1'b0;

        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_retire", retire_valid, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_head", head, 0);

        // Three allocations, tags 0..2
        for (int i = 0; i < 3; i++) begin
            chk("alloc_tag_seq", alloc_tag, i);
            alloc(7'(10 + i), 1'b1);
        end
        chk("alloc3_count", count, 3);
        chk("alloc3_empty", empty, 0);
        chk("alloc3_retire", retire_valid, 0);

        // All three complete together; two retire, then one
        wb(0, 4'd0);
        wb(1, 4'd1);
        wb(2, 4'd2);
        exp_ret.push_back({1'b1, 7'd10});
        exp_ret.push_back({1'b1, 7'd11});
        exp_ret.push_back({1'b1, 7'd12});
        step();
        idle();
        chk("ret_first", retire_valid, 2'b11);
        step();
        chk("ret_second", retire_valid, 2'b01);
        step();
        chk("ret_drained_count", count, 0);
        chk("ret_drained_rv", retire_valid, 0);
        chk("ret_head", head, 3);

        // Younger completes first: nothing retires until the older one does
        alloc(7'd20, 1'b1);
        alloc(7'd21, 1'b1);
        wb(0, 4'd4);
        step();
        idle();
        chk("ooo_blocked", retire_valid, 0);
        wb(1, 4'd3);
        exp_ret.push_back({1'b1, 7'd20});
        exp_ret.push_back({1'b1, 7'd21});
        step();
        idle();
        chk("ooo_release", retire_valid, 2'b11);
        step();
        chk("ooo_count", count, 0);

        // Fill to capacity from tag 0
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(7'(30 + i), 1'b1);
        end
        chk("full_flag", full, 1);
        chk("full_ready", alloc_ready, 0);
        chk("full_tag_wrap", alloc_tag, 0);
        chk("full_count", count, 16);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("full_overflow_count", count, 16);

        // Mispredict at tag 3 with a concurrent alloc that must be dropped
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(7'(40 + i), (i != 3));
        end
        chk("pre_flush_ready", alloc_ready, 1);
        alloc_valid   = 1'b1;
        alloc_pd_old  = 7'd99;
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_tag        = 4'd3;
        br_target_pc  = 32'h40;
        exp_mis.push_back({4'd3, 32'h40});
        step();
        idle();
        chk("flush_pulse", mispredict, 1);
        chk("flush_ready_low", alloc_ready, 0);
        chk("flush_count", count, 4);
        chk("flush_alloc_tag", alloc_tag, 4);
        step();
        chk("flush_pulse_end", mispredict, 0);
        wb(1, 4'd5);
        step();
        idle();
        chk("flushed_wb_count", count, 4);
        chk("flushed_wb_rv", retire_valid, 0);
        wb(0, 4'd0);
        wb(1, 4'd1);
        wb(2, 4'd2);
        exp_ret.push_back({1'b1, 7'd40});
        exp_ret.push_back({1'b1, 7'd41});
        exp_ret.push_back({1'b1, 7'd42});
        exp_ret.push_back({1'b0, 7'd43});
        step();
        idle();
        chk("post_flush_ret1", retire_valid, 2'b11);
        step();
        chk("post_flush_ret2", retire_valid, 2'b11);
        step();
        chk("post_flush_count", count, 0);

        // Move head to 14, then flush across the wrap point
        do_reset();
        for (int i = 0; i < 14; i++) begin
            alloc(7'(i), 1'b0);
        end
        for (int i = 0; i < 14; i++) begin
            wb(0, 4'(i));
            exp_ret.push_back({1'b0, 7'(i)});
            step();
        end
        idle();
        for (int n = 0; n < 40 && count != 0; n++) begin
            step();
        end
        chk("wrap_drain_count", count, 0);
        chk("wrap_head", head, 14);
        for (int i = 0; i < 4; i++) begin
            alloc(7'(50 + i), 1'b1);
        end
        chk("wrap_count4", count, 4);
        br_valid      = 1'b1;
        br_mispredict = 1'b1;
        br_tag        = 4'd15;
        br_target_pc  = 32'h80;
        exp_mis.push_back({4'd15, 32'h80});
        step();
        idle();
        chk("wrap_flush_count", count, 2);
        chk("wrap_flush_tail", alloc_tag, 0);
        chk("wrap_flush_head", head, 14);
        step();
        wb(0, 4'd14);
        wb(1, 4'd1);
        wb(2, 4'd0);
        exp_ret.push_back({1'b1, 7'd50});
        exp_ret.push_back({1'b1, 7'd51});
        step();
        idle();
        chk("wrap_retire", retire_valid, 2'b11);

        // Reset while two entries are retiring
        reset = 1'b1;
        step();
        chk("mid_rst_rv", retire_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_head", head, 0);
        chk("mid_rst_tag", alloc_tag, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ready", alloc_ready, 1);
        chk("mid_rst_mis", mispredict, 0);
        chk("mid_rst_mis_tag", mispredict_tag, 0);
        chk("mid_rst_mis_pc", mispredict_pc, 0);
        reset = 1'b0;
        step();

        chk("sb_retire_empty", exp_ret.size(), 0);
        chk("sb_mis_empty", exp_mis.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
Parametrised reorder buffer, successor to the single-commit ROB in the processor top level. It allocates entries in program order from dispatch and accepts completions from NUM_WB writeback ports. It retires up to COMMIT_WIDTH consecutive completed entries per cycle and frees their old physical registers to rename. On a branch mispredict it flushes every entry younger than the branch and reports the recovery tag and PC.

Parameters:
DEPTH, 16, number of entries; power of two, >=4
COMMIT_WIDTH, 2, maximum retirements per cycle; 1..4
NUM_WB, 3, number of completion ports (alu, branch, mem)
PREG_W, 7, physical register index width
TAG_W, $clog2(DEPTH), ROB tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
alloc_valid  in  1  dispatch allocates one entry this cycle
alloc_pd_new  in  PREG_W  new destination preg
alloc_pd_old  in  PREG_W  previous mapping of arch rd
alloc_has_rd  in  1  entry writes a register
alloc_pc  in  32  instruction PC
alloc_ready  out  1  entry accepted when alloc_valid&&alloc_ready
alloc_tag  out  TAG_W  tag assigned to the current allocation (tail)
wb_valid  in  NUM_WB  per-port completion strobe
wb_tag  in  NUM_WB*TAG_W  packed completion tags, port i at [i*TAG_W +: TAG_W]
br_valid  in  1  branch resolved
br_tag  in  TAG_W  resolved branch tag
br_mispredict  in  1  resolution was wrong
br_target_pc  in  32  correct fetch PC
retire_valid  out  COMMIT_WIDTH  slot k retires; thermometer, contiguous from bit 0
retire_has_rd  out  COMMIT_WIDTH  slot k frees a preg
retire_pd_old  out  COMMIT_WIDTH*PREG_W  preg to free, slot k at [k*PREG_W +: PREG_W]
head  out  TAG_W  oldest entry tag
mispredict  out  1  one-cycle flush pulse
mispredict_tag  out  TAG_W  tag of mispredicted branch
mispredict_pc  out  32  redirect PC
count  out  TAG_W+1  occupied entries
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- State per entry: valid, done, has_rd, pd_new, pd_old, pc. Head and tail pointers are TAG_W+1 bits; the extra bit is the wrap bit. count = tail-head.
- Reset: all valid/done cleared, head=tail=0, count=0, empty=1, full=0, alloc_ready=1.
- Reset: retire_valid=0, mispredict=0, mispredict_tag=0, mispredict_pc=0.
- Reset takes priority over every other input in the same cycle.
- Allocation: alloc_ready = !full && !mispredict, decoded from registered state only. alloc_tag = tail[TAG_W-1:0].
- On accept: entry written valid, done=0, and tail increments with wrap.
- Completion: wb_valid[i] sets done on entry wb_tag[i] when that entry is valid. br_valid also sets done on br_tag. Completions to invalid entries are ignored.
- Multiple ports may hit distinct tags in the same cycle, and all are applied. If they hit the same tag, the result is the same (idempotent).
- Retire is combinational from registered state. Slot k is valid iff entries head..head+k are all valid&&done and k<count. retire_valid is therefore a thermometer code.
- At the edge, retired entries are invalidated and head advances by popcount(retire_valid), with wrap.
- A completion arriving this cycle cannot retire until the next cycle (latency 1).
- Mispredict: when br_valid&&br_mispredict, at the next edge:
  - entries strictly younger than br_tag (age relative to head) are invalidated;
  - tail becomes br_tag+1 with the correct wrap bit;
  - mispredict pulses high for exactly one cycle;
  - mispredict_tag=br_tag and mispredict_pc=br_target_pc.
- Any alloc in the mispredict cycle is discarded.
- The branch entry itself stays, marked done. Older entries, and the branch itself, may retire in the same cycle as the flush.
- Completions in the mispredict cycle that target flushed tags are dropped. Completions targeting older entries are applied.
- br_mispredict with br_tag not valid is ignored entirely.
- Simultaneous alloc and retire update tail and head independently, and count reflects both.
- Full wraps correctly: DEPTH allocations with no retirement give full=1 and alloc_ready=0.

Test Plan:
- Reset, then alloc 3 entries (pd_old 10,11,12, all has_rd) → alloc_tag 0,1,2; count=3; empty=0; retire_valid=0.
- Complete tags 0,1,2 via wb ports 0,1,2 in one cycle → next cycle retire_valid=2'b11 with pd_old 10,11; following cycle retire_valid=2'b01 with pd_old 12; count=0.
- Complete tag 1 only, with tag 0 pending → retire_valid=0. Then complete tag 0 → retire 0 and 1 together.
- Alloc 16 entries with no completion → full=1, alloc_ready=0, alloc_tag=0 (wrapped). A 17th alloc_valid leaves count at 16.
- Alloc tags 0..7, then br_valid+br_mispredict at br_tag=3 with pc 0x40 and a concurrent alloc → next cycle mispredict=1, mispredict_tag=3, mispredict_pc=0x40; then count=4 and alloc_tag=4. A later wb to tag 5 has no effect.
- Wrap-around flush: head=14, branch at tag 15 (entries 14..1 valid), mispredict → tail=0, entries 0,1 invalid, count=2. Assert reset mid-sequence → all outputs return to reset values the next cycle.
